// File: rtl/reg_bank_loader_if.sv
// Byte-stream handshake bundle between a configuration host and reg_bank_loader.
// rx carries host-to-block bytes, tx carries readback bytes; both use valid/ready.
interface reg_bank_loader_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output tx_data,
        output tx_valid,
        input  tx_ready
    );
endinterface

// File: rtl/reg_bank_loader.sv
// Byte-serial configuration front end owning a 64 x 16-bit register bank.
// Write frame: {1'b1,1'b0,addr[5:0]}, data_hi, data_lo. Read: {1'b0,1'b0,addr}, two tx bytes.
module reg_bank_loader #(
    parameter logic [15:0] RESET_VALUE = 16'h0000,
    parameter int unsigned TIMEOUT     = 32'd255
) (
    input  logic                clk,
    input  logic                rst_n,
    reg_bank_loader_if.slave    bus,
    output logic [15:0]         regs [63:0],
    output logic                wr_strobe,
    output logic [5:0]          wr_index,
    output logic                frame_err,
    input  logic                err_clr
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] DATA_HI = 3'd1;
    localparam logic [2:0] DATA_LO = 3'd2;
    localparam logic [2:0] RD_HI   = 3'd3;
    localparam logic [2:0] RD_LO   = 3'd4;

    logic [2:0]  state_r;
    logic [2:0]  state_nxt_s;
    logic [5:0]  addr_r;
    logic [5:0]  addr_nxt_s;
    logic [7:0]  data_hi_r;
    logic [7:0]  data_hi_nxt_s;
    // High snapshot byte goes straight to tx_data at command accept; only the low byte waits.
    logic [7:0]  snap_lo_r;
    logic [7:0]  snap_lo_nxt_s;
    logic [7:0]  tx_data_r;
    logic [7:0]  tx_data_nxt_s;
    logic        tx_valid_r;
    logic        tx_valid_nxt_s;
    logic        rx_ready_r;
    logic        rx_ready_nxt_s;
    logic [31:0] cnt_r;
    logic [31:0] cnt_nxt_s;
    logic        frame_err_r;
    logic        frame_err_nxt_s;
    logic        wr_strobe_r;
    logic [5:0]  wr_index_r;
    logic        wr_en_s;
    logic        err_set_s;
    logic        rx_fire_s;
    logic        tx_fire_s;
    logic        tmo_hit_s;
    logic [15:0] regs_r [63:0];

    assign rx_fire_s = bus.rx_valid & rx_ready_r;
    assign tx_fire_s = tx_valid_r & bus.tx_ready;
    // A byte landing in the cycle the count equals TIMEOUT still wins over the timeout.
    assign tmo_hit_s = (TIMEOUT != 32'd0) && (cnt_r == TIMEOUT);

    // Frame decoder: next state, latched fields, timeout counter and error set.
    always_comb begin
        state_nxt_s   = state_r;
        addr_nxt_s    = addr_r;
        data_hi_nxt_s = data_hi_r;
        snap_lo_nxt_s = snap_lo_r;
        tx_data_nxt_s = tx_data_r;
        cnt_nxt_s     = 32'd0;
        wr_en_s       = 1'b0;
        err_set_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (rx_fire_s) begin
                    if (bus.rx_data[6]) begin
                        err_set_s = 1'b1;
                    end else if (bus.rx_data[7]) begin
                        addr_nxt_s  = bus.rx_data[5:0];
                        state_nxt_s = DATA_HI;
                    end else begin
                        snap_lo_nxt_s = regs_r[bus.rx_data[5:0]][7:0];
                        tx_data_nxt_s = regs_r[bus.rx_data[5:0]][15:8];
                        state_nxt_s   = RD_HI;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            DATA_HI: begin
                if (rx_fire_s) begin
                    data_hi_nxt_s = bus.rx_data;
                    state_nxt_s   = DATA_LO;
                end else if (tmo_hit_s) begin
                    err_set_s   = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    cnt_nxt_s = cnt_r + 32'd1;
                end
            end
            DATA_LO: begin
                if (rx_fire_s) begin
                    wr_en_s     = 1'b1;
                    state_nxt_s = IDLE;
                end else if (tmo_hit_s) begin
                    err_set_s   = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    cnt_nxt_s = cnt_r + 32'd1;
                end
            end
            RD_HI: begin
                if (tx_fire_s) begin
                    tx_data_nxt_s = snap_lo_r;
                    state_nxt_s   = RD_LO;
                end else begin
                    state_nxt_s = RD_HI;
                end
            end
            RD_LO: begin
                if (tx_fire_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RD_LO;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Output handshakes are decoded from the next state so they are registered.
    always_comb begin
        rx_ready_nxt_s = 1'b0;
        tx_valid_nxt_s = 1'b0;
        case (state_nxt_s)
            IDLE, DATA_HI, DATA_LO: rx_ready_nxt_s = 1'b1;
            RD_HI, RD_LO:           tx_valid_nxt_s = 1'b1;
            default: begin
                rx_ready_nxt_s = 1'b0;
                tx_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // Sticky error: a new violation outranks a simultaneous clear.
    always_comb begin
        frame_err_nxt_s = frame_err_r;
        if (err_set_s) begin
            frame_err_nxt_s = 1'b1;
        end else if (err_clr) begin
            frame_err_nxt_s = 1'b0;
        end else begin
            frame_err_nxt_s = frame_err_r;
        end
    end

    // Control and handshake state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            addr_r      <= 6'd0;
            data_hi_r   <= 8'd0;
            snap_lo_r   <= 8'd0;
            tx_data_r   <= 8'd0;
            tx_valid_r  <= 1'b0;
            rx_ready_r  <= 1'b0;
            cnt_r       <= 32'd0;
            frame_err_r <= 1'b0;
            wr_strobe_r <= 1'b0;
            wr_index_r  <= 6'd0;
        end else begin
            state_r     <= state_nxt_s;
            addr_r      <= addr_nxt_s;
            data_hi_r   <= data_hi_nxt_s;
            snap_lo_r   <= snap_lo_nxt_s;
            tx_data_r   <= tx_data_nxt_s;
            tx_valid_r  <= tx_valid_nxt_s;
            rx_ready_r  <= rx_ready_nxt_s;
            cnt_r       <= cnt_nxt_s;
            frame_err_r <= frame_err_nxt_s;
            wr_strobe_r <= wr_en_s;
            wr_index_r  <= wr_en_s ? addr_r : wr_index_r;
        end
    end

    // Register bank storage; the only write path is a completed frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) begin
                regs_r[i] <= RESET_VALUE;
            end
        end else if (wr_en_s) begin
            regs_r[addr_r] <= {data_hi_r, bus.rx_data};
        end else begin
            regs_r[addr_r] <= regs_r[addr_r];
        end
    end

    assign regs         = regs_r;
    assign bus.rx_ready = rx_ready_r;
    assign bus.tx_data  = tx_data_r;
    assign bus.tx_valid = tx_valid_r;
    assign wr_strobe    = wr_strobe_r;
    assign wr_index     = wr_index_r;
    assign frame_err    = frame_err_r;

endmodule
